s3rb_issuer: RTL and testbench

- Instruction sequencer that drives the s3rb execution core: it is the initiator for the core's opcode/operand1/operand2 inputs and the consumer of its done/aluout/cb outputs.
- Holds a small loadable program memory and issues one instruction at a time. It waits for the core's done handshake, captures each result and advances to the next instruction.
- Sits between a host/testbench loader and the s3rb core.

---
 rtl/s3rb_issuer.sv | 211 +++++++++++++++++++++
 tb/tb_s3rb_issuer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3rb_issuer.sv
// -----------------------------------------------------------------------------
// s3rb_issuer
// Instruction sequencer for the s3rb execution core. A host loads a small
// program memory, then pulses start. Instructions are issued one at a time.
// For each one the sequencer waits for the core's done, captures the result,
// waits for done to drop again, and then moves to the next entry.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, prog_len     begin a run of prog_len instructions from entry 0
//   prog_we/addr/data   program memory write port (ignored while busy)
//   opcode/operand1/2   registered instruction fields driven to the core
//   core_done/aluout/cb handshake and result from the core
//   res_valid/data/cb   one-cycle result pulse with the captured values
//   res_idx             program index of the captured result
//   busy                run in progress
//   seq_done            one-cycle pulse when a run completes
//   timeout_err         sticky; the core stalled for more than TIMEOUT cycles
// -----------------------------------------------------------------------------
module s3rb_issuer #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [23:0]   prog_data,
    output logic [3:0]    opcode,
    output logic [3:0]    operand1,
    output logic [15:0]   operand2,
    input  logic          core_done,
    input  logic [15:0]   core_aluout,
    input  logic          core_cb,
    output logic          res_valid,
    output logic [15:0]   res_data,
    output logic          res_cb,
    output logic [AW-1:0] res_idx,
    output logic          busy,
    output logic          seq_done,
    output logic          timeout_err
);
    localparam int          DEPTH   = 2 ** AW;
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_REL,
        S_FINISH,
        S_ERR
    } state_t;

    logic [23:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [23:0]   instr_q;
    logic          issue_en;
    logic          res_valid_q, res_valid_d;
    logic [15:0]   res_data_q, res_data_d;
    logic          res_cb_q, res_cb_d;
    logic [AW-1:0] res_idx_q, res_idx_d;
    logic          busy_q, busy_d;
    logic          seq_done_q, seq_done_d;
    logic          err_q, err_d;

    logic          timer_expired;
    logic          last_instr;

    assign timer_expired = (timer_q == TW'(TIMEOUT));
    assign last_instr    = (({1'b0, pc_q} + LEN_ONE) == len_q);

    // Program memory: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            timer_q     <= '0;
            instr_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cb_q    <= 1'b0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            timer_q     <= timer_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cb_q    <= res_cb_d;
            res_idx_q   <= res_idx_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            err_q       <= err_d;
            // Registered memory read; the fields then hold until the next issue.
            if (issue_en) begin
                instr_q <= mem[pc_q];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        timer_d     = timer_q;
        issue_en    = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_cb_d    = res_cb_q;
        res_idx_d   = res_idx_q;
        busy_d      = busy_q;
        seq_done_d  = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    err_d = 1'b0;
                    if (prog_len == '0) begin
                        // Empty program: report completion without going busy.
                        seq_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                        pc_d    = '0;
                        busy_d  = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue_en = 1'b1;
                timer_d  = '0;
                state_d  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    res_valid_d = 1'b1;
                    res_data_d  = core_aluout;
                    res_cb_d    = core_cb;
                    res_idx_d   = pc_q;
                    timer_d     = '0;
                    state_d     = S_WAIT_REL;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_REL: begin
                // Wait for done to drop so a level-held done is counted once.
                if (!core_done) begin
                    if (last_instr) begin
                        state_d = S_FINISH;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_ISSUE;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FINISH: begin
                seq_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign opcode      = instr_q[23:20];
    assign operand1    = instr_q[19:16];
    assign operand2    = instr_q[15:0];
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_cb      = res_cb_q;
    assign res_idx     = res_idx_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_s3rb_issuer.sv
// -----------------------------------------------------------------------------
// Testbench for s3rb_issuer: directed scenarios followed by randomized traffic,
// with every output compared each cycle against a behavioural model of the
// sequencer's observable protocol, plus literal checks on known scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_s3rb_issuer;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [23:0]   prog_data = '0;
    logic          core_done = 1'b0;
    logic [15:0]   core_aluout = '0;
    logic          core_cb = 1'b0;
    logic [3:0]    opcode, operand1;
    logic [15:0]   operand2;
    logic          res_valid;
    logic [15:0]   res_data;
    logic          res_cb;
    logic [AW-1:0] res_idx;
    logic          busy, seq_done, timeout_err;

    s3rb_issuer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .core_done(core_done), .core_aluout(core_aluout), .core_cb(core_cb),
        .res_valid(res_valid), .res_data(res_data), .res_cb(res_cb),
        .res_idx(res_idx), .busy(busy), .seq_done(seq_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (updated at each rising edge) --------
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_RESULT = 2, PH_REL = 3, PH_FIN = 4;
    logic [23:0] m_mem [DEPTH];
    int          ph = PH_IDLE, m_pc = 0, m_len = 0, m_stall = 0;
    bit          m_issue_pulse = 1'b0;
    logic [23:0] e_instr = '0;
    logic        e_res_valid = 1'b0, e_res_cb = 1'b0;
    logic [15:0] e_res_data = '0;
    int          e_res_idx = 0;
    logic        e_busy = 1'b0, e_seq_done = 1'b0, e_err = 1'b0;

    always @(posedge clk) begin
        m_issue_pulse = 1'b0;
        e_res_valid   = 1'b0;
        e_seq_done    = 1'b0;
        if (rst) begin
            ph = PH_IDLE; m_pc = 0; e_instr = '0; e_res_data = '0; e_res_cb = 1'b0;
            e_res_idx = 0; e_busy = 1'b0; e_err = 1'b0;
        end else begin
            if (prog_we && !e_busy) m_mem[prog_addr] = prog_data;
            case (ph)
                PH_IDLE: if (start) begin
                    e_err = 1'b0;
                    if (prog_len == 0) e_seq_done = 1'b1;
                    else begin
                        m_len = (prog_len > DEPTH) ? DEPTH : int'(prog_len);
                        m_pc = 0; e_busy = 1'b1; ph = PH_ISSUE;
                    end
                end
                PH_ISSUE: begin
                    e_instr = m_mem[m_pc]; m_stall = 0; m_issue_pulse = 1'b1; ph = PH_RESULT;
                end
                PH_RESULT: begin
                    if (core_done) begin
                        e_res_valid = 1'b1; e_res_data = core_aluout; e_res_cb = core_cb;
                        e_res_idx = m_pc; m_stall = 0; ph = PH_REL;
                    end else begin
                        m_stall++;
                        if (m_stall > TIMEOUT) begin e_err = 1'b1; e_busy = 1'b0; ph = PH_IDLE; end
                    end
                end
                PH_REL: begin
                    if (!core_done) begin
                        if (m_pc == m_len - 1) ph = PH_FIN;
                        else begin m_pc++; ph = PH_ISSUE; end
                    end else begin
                        m_stall++;
                        if (m_stall > TIMEOUT) begin e_err = 1'b1; e_busy = 1'b0; ph = PH_IDLE; end
                    end
                end
                PH_FIN: begin e_seq_done = 1'b1; e_busy = 1'b0; ph = PH_IDLE; end
                default: ph = PH_IDLE;
            endcase
        end
    end

    // ---------------- core responder ----------------------------------------
    // mode 0: never done; 1: done from resp_delay to resp_delay+resp_hold-1
    // cycles after each issue; 2: random done with probability resp_p percent.
    int          resp_mode = 0, resp_delay = 2, resp_hold = 1, resp_p = 50;
    int          since = 1000, n_iss = 0, list_base = 0;
    bit          use_list = 1'b0;
    logic [15:0] alu_list [4];

    always @(negedge clk) begin
        int k;
        if (m_issue_pulse) begin since = 1; n_iss++; end
        else if (since < 1000) since++;
        k = (n_iss - list_base - 1) & 3;
        case (resp_mode)
            1: begin
                core_done   = (since >= resp_delay) && (since < resp_delay + resp_hold);
                core_aluout = use_list ? alu_list[k] : 16'($urandom);
                core_cb     = 1'($urandom);
            end
            2: begin
                core_done   = ($urandom_range(0, 99) < resp_p);
                core_aluout = 16'($urandom);
                core_cb     = 1'($urandom);
            end
            default: core_done = 1'b0;
        endcase
    end

    // ---------------- checking ------------------------------------------------
    int          n_vec = 0, n_err = 0;
    int          n_resv = 0, n_seqd = 0, n_busy = 0;
    logic [43:0] caps [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output with the model.
    task automatic step();
        @(negedge clk);
        chk("opcode",      32'(opcode),      32'(e_instr[23:20]));
        chk("operand1",    32'(operand1),    32'(e_instr[19:16]));
        chk("operand2",    32'(operand2),    32'(e_instr[15:0]));
        chk("res_valid",   32'(res_valid),   32'(e_res_valid));
        chk("res_data",    32'(res_data),    32'(e_res_data));
        chk("res_cb",      32'(res_cb),      32'(e_res_cb));
        chk("res_idx",     32'(res_idx),     e_res_idx);
        chk("busy",        32'(busy),        32'(e_busy));
        chk("seq_done",    32'(seq_done),    32'(e_seq_done));
        chk("timeout_err", 32'(timeout_err), 32'(e_err));
        if (res_valid) begin
            n_resv++;
            caps.push_back({res_idx, res_data, opcode, operand1, operand2});
        end
        if (seq_done) n_seqd++;
        if (busy) n_busy++;
    endtask

    task automatic clr_mon();
        n_resv = 0; n_seqd = 0; n_busy = 0; caps.delete();
    endtask

    task automatic prog_write(input int a, input logic [23:0] d);
        prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        start = 1'b1; prog_len = len[AW:0];
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int c = 0;
        while (!seq_done && !timeout_err && c < budget) begin step(); c++; end
        if (!(seq_done || timeout_err)) begin
            n_vec++; n_err++;
            $display("FAIL %s: no completion within %0d cycles", name, budget);
        end
    endtask

    task automatic chk_cap(input string name, input int k, input int idx, input logic [23:0] instr);
        if (k >= caps.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: capture %0d missing, only %0d seen", name, k, caps.size());
        end else begin
            chk({name, "_idx"},   32'(caps[k][43:40]), idx);
            chk({name, "_instr"}, 32'(caps[k][23:0]),  32'(instr));
        end
    endtask

    task automatic chk_capd(input string name, input int k, input logic [15:0] data);
        if (k >= caps.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: capture %0d missing, only %0d seen", name, k, caps.size());
        end else begin
            chk(name, 32'(caps[k][39:24]), 32'(data));
        end
    endtask

    initial begin
        int ps [4];
        int c;
        ps = '{5, 45, 75, 97};

        // Reset state
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_ops", 32'({opcode, operand1, operand2}), 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) prog_write(i, 24'($urandom));
        prog_write(0, 24'h120005);
        prog_write(1, 24'h3400FF);

        // T1: two-instruction run, done 2 cycles after each issue
        resp_mode = 1; resp_delay = 2; resp_hold = 1;
        use_list = 1'b1; list_base = n_iss;
        alu_list[0] = 16'h00AA; alu_list[1] = 16'h1234;
        clr_mon();
        pulse_start(2);
        chk("t1_busy_after_start", 32'(busy), 1);
        step();
        chk("t1_first_issue", 32'({opcode, operand1, operand2}), 32'h120005);
        wait_end("t1", 60);
        chk("t1_nres", n_resv, 2);
        chk("t1_nseq", n_seqd, 1);
        chk("t1_busy_cycles", n_busy, 9);
        chk_cap("t1_cap0", 0, 0, 24'h120005);
        chk_cap("t1_cap1", 1, 1, 24'h3400FF);
        chk_capd("t1_data0", 0, 16'h00AA);
        chk_capd("t1_data1", 1, 16'h1234);
        step();
        chk("t1_busy_end", 32'(busy), 0);

        // T2: done held high for 5 extra cycles after each result
        resp_delay = 2; resp_hold = 6; use_list = 1'b0;
        clr_mon();
        pulse_start(2);
        wait_end("t2", 80);
        chk("t2_nres", n_resv, 2);
        chk("t2_busy_cycles", n_busy, 19);
        step();

        // T3: core never responds -> timeout, then recovery
        resp_mode = 0;
        clr_mon();
        pulse_start(2);
        wait_end("t3", 80);
        chk("t3_err", 32'(timeout_err), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_busy_cycles", n_busy, 17);
        chk("t3_nres", n_resv, 0);
        step();
        resp_mode = 1; resp_delay = 1; resp_hold = 1;
        clr_mon();
        pulse_start(1);
        chk("t3_err_cleared", 32'(timeout_err), 0);
        wait_end("t3b", 40);
        chk("t3b_nseq", n_seqd, 1);
        chk("t3b_nres", n_resv, 1);
        step();

        // T4: empty program
        clr_mon();
        pulse_start(0);
        chk("t4_seq_done", 32'(seq_done), 1);
        chk("t4_busy", 32'(busy), 0);
        repeat (4) step();
        chk("t4_nres", n_resv, 0);
        chk("t4_nbusy", n_busy, 0);
        chk("t4_nseq", n_seqd, 1);

        // T5: reset during instruction 1, then replay
        resp_delay = 3; resp_hold = 1;
        clr_mon();
        pulse_start(3);
        c = 0;
        while (!(ph == PH_RESULT && m_pc == 1) && c < 40) begin step(); c++; end
        chk("t5_reached_wait", 32'(c < 40), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ops", 32'({opcode, operand1, operand2}), 0);
        chk("t5_rst_res", 32'({res_valid, res_cb, res_idx, res_data}), 0);
        step();
        use_list = 1'b1; list_base = n_iss;
        alu_list[0] = 16'h1111; alu_list[1] = 16'h2222; alu_list[2] = 16'h3333;
        clr_mon();
        pulse_start(3);
        wait_end("t5", 60);
        chk("t5_nres", n_resv, 3);
        chk_cap("t5_cap0", 0, 0, 24'h120005);
        chk_cap("t5_cap1", 1, 1, 24'h3400FF);
        chk_capd("t5_data2", 2, 16'h3333);
        step();

        // T6: write and start while busy are both ignored
        use_list = 1'b0; resp_delay = 2;
        clr_mon();
        pulse_start(3);
        step();
        prog_write(0, 24'hFFFFFF);
        start = 1'b1; prog_len = 5'd1;
        step();
        start = 1'b0;
        wait_end("t6", 60);
        chk("t6_nres", n_resv, 3);
        chk("t6_nseq", n_seqd, 1);
        step();
        clr_mon();
        pulse_start(1);
        wait_end("t6b", 30);
        chk_cap("t6_cap0", 0, 0, 24'h120005);
        step();

        // Randomized traffic
        for (int blk = 0; blk < 12; blk++) begin
            resp_mode = 2; resp_p = ps[blk % 4];
            for (int i = 0; i < 500; i++) begin
                rst       = ($urandom_range(0, 999) < 4);
                prog_we   = !rst && ($urandom_range(0, 3) == 0);
                prog_addr = 4'($urandom);
                prog_data = 24'($urandom);
                start     = !rst && ($urandom_range(0, 15) == 0);
                prog_len  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                                         : 5'($urandom_range(0, 16));
                step();
            end
        end
        rst = 1'b0; prog_we = 1'b0; start = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
